// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bridge: FSM encoding, SPI mode bit
// positions and the sizing rule for the shared bit counter.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int SPI_CPHA_BIT = 0;
    localparam int SPI_CPOL_BIT = 1;

    // The bit counter covers the longer of the command word and a data word.
    function automatic int bit_cnt_width(input int addr_w, input int data_w);
        int longest;
        longest = (addr_w + 1 > data_w) ? addr_w + 1 : data_w;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and flags single-cycle
// edges of SSEL and SCK on the synchronised copies.
module spi_sync_edge #(
    parameter logic SCK_IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ssel_raw,
    input  logic sck_raw,
    input  logic mosi_raw,
    output logic ssel_fall,
    output logic ssel_rise,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_sync
);

    logic ssel_meta;
    logic ssel_sync;
    logic ssel_prev;
    logic sck_meta;
    logic sck_sync;
    logic sck_prev;
    logic mosi_meta;

    // Two-flop synchronisers plus one history flop per line; reset holds the idle bus levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssel_meta <= 1'b1;
            ssel_sync <= 1'b1;
            ssel_prev <= 1'b1;
            sck_meta  <= SCK_IDLE;
            sck_sync  <= SCK_IDLE;
            sck_prev  <= SCK_IDLE;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            ssel_meta <= ssel_raw;
            ssel_sync <= ssel_meta;
            ssel_prev <= ssel_sync;
            sck_meta  <= sck_raw;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            mosi_meta <= mosi_raw;
            mosi_sync <= mosi_meta;
        end
    end

    assign ssel_fall = ssel_prev & ~ssel_sync;
    assign ssel_rise = ~ssel_prev & ssel_sync;
    assign sck_rise  = ~sck_prev & sck_sync;
    assign sck_fall  = sck_prev & ~sck_sync;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI slave that turns command/address/data frames into single-cycle register
// write strobes and read requests, with optional burst address increment.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int SPI_MODE = 0,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              DSP_SSEL,
    input  logic              DSP_SCK,
    input  logic              DSP_MOSI,
    output logic              DSP_MISO,
    output logic              DSP_MISO_OE,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_err
);

    localparam int              CNT_W     = bit_cnt_width(ADDR_W, DATA_W);
    localparam logic [1:0]      MODE_BITS = 2'(SPI_MODE);
    localparam logic            CPOL      = MODE_BITS[SPI_CPOL_BIT];
    localparam logic            CPHA      = MODE_BITS[SPI_CPHA_BIT];
    localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

    logic ssel_fall;
    logic ssel_rise;
    logic sck_rise;
    logic sck_fall;
    logic mosi_sync;
    logic sample_edge;
    logic shift_edge;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W-1:0]   cmd_sr;
    logic [DATA_W-2:0]   data_sr;
    logic [DATA_W-1:0]   shift_out;
    logic                rw;
    logic                miso_en;
    logic                cap_pending;
    logic                adv_pending;

    logic [ADDR_W:0]     cmd_word;
    logic [DATA_W-1:0]   data_word;
    logic [ADDR_W-1:0]   addr_next;

    spi_sync_edge #(
        .SCK_IDLE (CPOL)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ssel_raw  (DSP_SSEL),
        .sck_raw   (DSP_SCK),
        .mosi_raw  (DSP_MOSI),
        .ssel_fall (ssel_fall),
        .ssel_rise (ssel_rise),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .mosi_sync (mosi_sync)
    );

    // Sampling happens on the rising edge when CPOL matches CPHA, the falling edge otherwise.
    assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
    assign shift_edge  = (CPOL == CPHA) ? sck_fall : sck_rise;

    assign cmd_word  = {cmd_sr, mosi_sync};
    assign data_word = {data_sr, mosi_sync};
    assign addr_next = (AUTO_INC != 0) ? reg_addr + ADDR_W'(1) : reg_addr;

    assign busy        = (state != ST_IDLE);
    assign DSP_MISO_OE = busy;
    assign DSP_MISO    = miso_en & shift_out[DATA_W-1];

    // Frame FSM: collects the command, issues write strobes and read prefetches, drives the MISO shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            data_sr     <= '0;
            shift_out   <= '0;
            rw          <= 1'b0;
            miso_en     <= 1'b0;
            cap_pending <= 1'b0;
            adv_pending <= 1'b0;
            reg_addr    <= '0;
            wr_data     <= '0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            frame_err   <= 1'b0;
            adv_pending <= 1'b0;
            cap_pending <= rd_en;
            if (adv_pending) begin
                reg_addr <= addr_next;
            end
            if (cap_pending) begin
                shift_out <= rd_data;
            end
            case (state)
                ST_IDLE: begin
                    if (ssel_fall) begin
                        state     <= ST_CMD;
                        bit_cnt   <= '0;
                        shift_out <= '0;
                        miso_en   <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (ssel_rise) begin
                        state     <= ST_IDLE;
                        bit_cnt   <= '0;
                        frame_err <= 1'b1;
                    end else if (sample_edge) begin
                        if (bit_cnt == LAST_CMD) begin
                            state    <= ST_DATA;
                            bit_cnt  <= '0;
                            rw       <= cmd_word[ADDR_W];
                            reg_addr <= cmd_word[ADDR_W-1:0];
                            rd_en    <= cmd_word[ADDR_W];
                            miso_en  <= cmd_word[ADDR_W];
                        end else begin
                            cmd_sr  <= cmd_word[ADDR_W-1:0];
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (ssel_rise) begin
                        state     <= ST_IDLE;
                        bit_cnt   <= '0;
                        miso_en   <= 1'b0;
                        frame_err <= (bit_cnt != '0);
                    end else begin
                        if (sample_edge) begin
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                if (rw) begin
                                    reg_addr <= addr_next;
                                    rd_en    <= 1'b1;
                                end else begin
                                    wr_en       <= 1'b1;
                                    wr_data     <= data_word;
                                    adv_pending <= 1'b1;
                                end
                            end else begin
                                data_sr <= data_word[DATA_W-2:0];
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (shift_edge && rw && (bit_cnt != '0)) begin
                            shift_out <= shift_out << 1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: four instances cover mode 0 with and
// without auto-increment, mode 1 and mode 3, sharing SCK/MOSI with private selects.
module tb_spi_reg_bridge;

    localparam int N  = 4;
    localparam int HP = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] ssel;
    logic sck;
    logic mosi;
    logic [N-1:0] miso;
    logic [N-1:0] miso_oe;
    logic [N-1:0] wr_en;
    logic [N-1:0] rd_en;
    logic [N-1:0] busy;
    logic [N-1:0] frame_err;
    logic [N-1:0][6:0] reg_addr;
    logic [N-1:0][7:0] wr_data;
    logic [N-1:0][7:0] rd_data;
    logic [7:0] mem [128];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;
    int clash_cnt = 0;
    int wide_cnt = 0;
    logic [6:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [6:0] rd_addr_q[$];
    logic [N-1:0] wr_prev = '0;
    logic [N-1:0] rd_prev = '0;
    logic [N-1:0] err_prev = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_reg_bridge #(
            .ADDR_W   (7),
            .DATA_W   (8),
            .SPI_MODE ((g == 2) ? 1 : ((g == 3) ? 3 : 0)),
            .AUTO_INC ((g == 1) ? 0 : 1)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .DSP_SSEL    (ssel[g]),
            .DSP_SCK     (sck),
            .DSP_MOSI    (mosi),
            .DSP_MISO    (miso[g]),
            .DSP_MISO_OE (miso_oe[g]),
            .wr_en       (wr_en[g]),
            .rd_en       (rd_en[g]),
            .reg_addr    (reg_addr[g]),
            .wr_data     (wr_data[g]),
            .rd_data     (rd_data[g]),
            .busy        (busy[g]),
            .frame_err   (frame_err[g])
        );
    end

    // Register file model: read data is valid on the clk after the request.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_en[i]) rd_data[i] <= mem[reg_addr[i]];
        end
    end

    // Strobe logger: records every strobe and flags overlapping or over-wide pulses.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wr_en[i]) begin
                wr_cnt++;
                wr_addr_q.push_back(reg_addr[i]);
                wr_data_q.push_back(wr_data[i]);
            end
            if (rd_en[i]) begin
                rd_cnt++;
                rd_addr_q.push_back(reg_addr[i]);
            end
            if (frame_err[i]) err_cnt++;
            if (wr_en[i] && rd_en[i]) clash_cnt++;
            if ((wr_en[i] && wr_prev[i]) || (rd_en[i] && rd_prev[i]) || (frame_err[i] && err_prev[i]))
                wide_cnt++;
        end
        wr_prev  = wr_en;
        rd_prev  = rd_en;
        err_prev = frame_err;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_cnt  = 0;
        rd_cnt  = 0;
        err_cnt = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic spi_begin(input int inst);
        ssel = '1;
        sck  = (inst == 3);
        wait_clks(HP);
        ssel[inst] = 1'b0;
        wait_clks(HP);
    endtask

    task automatic spi_end();
        wait_clks(HP);
        ssel = '1;
        wait_clks(4 * HP);
    endtask

    // Master shifts nbits (MSB first) and records MISO on each master sample edge.
    task automatic spi_shift(input int inst, input int nbits, input logic [63:0] bits,
                             output logic [63:0] seen, output logic sel_ok);
        logic cpol;
        logic cpha;
        cpol   = (inst == 3);
        cpha   = (inst >= 2);
        seen   = '0;
        sel_ok = 1'b1;
        for (int k = nbits - 1; k >= 0; k--) begin
            if (!cpha) begin
                mosi = bits[k];
                wait_clks(HP);
                sck    = ~cpol;
                seen   = {seen[62:0], miso[inst]};
                sel_ok = sel_ok & busy[inst] & miso_oe[inst];
                wait_clks(HP);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = bits[k];
                wait_clks(HP);
                sck    = cpol;
                seen   = {seen[62:0], miso[inst]};
                sel_ok = sel_ok & busy[inst] & miso_oe[inst];
                wait_clks(HP);
            end
        end
    endtask

    task automatic spi_frame(input int inst, input int nbits, input logic [63:0] bits,
                             output logic [63:0] seen, output logic sel_ok);
        spi_begin(inst);
        spi_shift(inst, nbits, bits, seen, sel_ok);
        spi_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ssel  = '1;
        sck   = 1'b0;
        mosi  = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        wait_clks(4);
        n_cmp++;
        if ({wr_en, rd_en, frame_err, busy, miso_oe, miso} !== 24'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_strobes: got %h want 000000", {wr_en, rd_en, frame_err, busy, miso_oe, miso});
        end
        n_cmp++;
        if (reg_addr !== 28'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_addr: got %h want 0", reg_addr);
        end
        n_cmp++;
        if (wr_data !== 32'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_wdata: got %h want 0", wr_data);
        end
        rst_n = 1'b1;
        wait_clks(4);
        n_cmp++;
        if (busy !== 4'h0) begin
            n_bad++;
            $display("[TB] FAIL idle_busy: got %h want 0", busy);
        end
        clear_logs();
    endtask

    task automatic test_write_mode0();
        logic [63:0] seen;
        logic sel_ok;
        clear_logs();
        spi_frame(0, 16, {48'h0, 1'b0, 7'h12, 8'hA5}, seen, sel_ok);
        n_cmp++;
        if (wr_cnt !== 1 || rd_cnt !== 0 || err_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL write_counts: got wr=%0d rd=%0d err=%0d want 1 0 0", wr_cnt, rd_cnt, err_cnt);
        end
        n_cmp++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 7'h12 || wr_data_q[0] !== 8'hA5) begin
            n_bad++;
            $display("[TB] FAIL write_addr_data: got %h/%h want 12/a5", reg_addr[0], wr_data[0]);
        end
        n_cmp++;
        if (seen[15:0] !== 16'h0000 || sel_ok !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL write_miso_busy: got miso=%h busy_ok=%b want 0000 1", seen[15:0], sel_ok);
        end
    endtask

    task automatic test_read_mode0();
        logic [63:0] seen;
        logic sel_ok;
        clear_logs();
        mem[7'h34] = 8'h5A;
        spi_frame(0, 16, {48'h0, 1'b1, 7'h34, 8'h00}, seen, sel_ok);
        n_cmp++;
        if (seen[15:0] !== 16'h005A) begin
            n_bad++;
            $display("[TB] FAIL read_miso: got %h want 005a", seen[15:0]);
        end
        n_cmp++;
        if (rd_cnt !== 2 || wr_cnt !== 0 || err_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL read_counts: got rd=%0d wr=%0d err=%0d want 2 0 0", rd_cnt, wr_cnt, err_cnt);
        end
        n_cmp++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 7'h34 || rd_addr_q[1] !== 7'h35) begin
            n_bad++;
            $display("[TB] FAIL read_addr: got %h want 34 then 35", rd_addr_q.size() > 0 ? rd_addr_q[0] : 7'h7f);
        end
    endtask

    task automatic test_burst_write(input int inst, input logic [20:0] want_addrs);
        logic [63:0] seen;
        logic sel_ok;
        clear_logs();
        spi_frame(inst, 32, {32'h0, 1'b0, 7'h7E, 8'h01, 8'h02, 8'h03}, seen, sel_ok);
        n_cmp++;
        if (wr_cnt !== 3 || err_cnt !== 0 || rd_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL burst_counts%0d: got wr=%0d err=%0d rd=%0d want 3 0 0", inst, wr_cnt, err_cnt, rd_cnt);
        end
        n_cmp++;
        if (wr_addr_q.size() != 3 || {wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]} !== want_addrs) begin
            n_bad++;
            $display("[TB] FAIL burst_addrs%0d: got %h want %h", inst,
                     wr_addr_q.size() == 3 ? {wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]} : 21'h0, want_addrs);
        end
        n_cmp++;
        if (wr_data_q.size() != 3 || {wr_data_q[0], wr_data_q[1], wr_data_q[2]} !== 24'h010203) begin
            n_bad++;
            $display("[TB] FAIL burst_data%0d: got %h want 010203", inst,
                     wr_data_q.size() == 3 ? {wr_data_q[0], wr_data_q[1], wr_data_q[2]} : 24'h0);
        end
    endtask

    task automatic test_read_burst();
        logic [63:0] seen;
        logic sel_ok;
        clear_logs();
        mem[7'h10] = 8'h11;
        mem[7'h11] = 8'hC7;
        spi_frame(0, 24, {40'h0, 1'b1, 7'h10, 16'h0000}, seen, sel_ok);
        n_cmp++;
        if (seen[23:0] !== 24'h0011C7) begin
            n_bad++;
            $display("[TB] FAIL rburst_miso: got %h want 0011c7", seen[23:0]);
        end
        n_cmp++;
        if (rd_addr_q.size() != 3 || {rd_addr_q[0], rd_addr_q[1], rd_addr_q[2]} !== {7'h10, 7'h11, 7'h12}) begin
            n_bad++;
            $display("[TB] FAIL rburst_addrs: got count %0d want 3 at 10,11,12", rd_addr_q.size());
        end
        n_cmp++;
        if (err_cnt !== 0 || wr_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL rburst_side: got err=%0d wr=%0d want 0 0", err_cnt, wr_cnt);
        end
    endtask

    task automatic test_partial_frame();
        logic [63:0] seen;
        logic sel_ok;
        clear_logs();
        spi_frame(0, 13, {51'h0, 1'b0, 7'h20, 5'b10110}, seen, sel_ok);
        n_cmp++;
        if (wr_cnt !== 0 || err_cnt !== 1) begin
            n_bad++;
            $display("[TB] FAIL partial_err: got wr=%0d err=%0d want 0 1", wr_cnt, err_cnt);
        end
        clear_logs();
        spi_frame(0, 16, {48'h0, 1'b0, 7'h21, 8'h3C}, seen, sel_ok);
        n_cmp++;
        if (wr_cnt !== 1 || err_cnt !== 0 || wr_addr_q.size() != 1 ||
            wr_addr_q[0] !== 7'h21 || wr_data_q[0] !== 8'h3C) begin
            n_bad++;
            $display("[TB] FAIL partial_recover: got wr=%0d err=%0d want 1 0 at 21/3c", wr_cnt, err_cnt);
        end
        clear_logs();
        spi_frame(0, 4, {60'h0, 4'b1010}, seen, sel_ok);
        n_cmp++;
        if (err_cnt !== 1 || rd_cnt !== 0 || wr_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL short_cmd: got err=%0d rd=%0d wr=%0d want 1 0 0", err_cnt, rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_modes(input int inst);
        logic [63:0] seen;
        logic sel_ok;
        clear_logs();
        mem[7'h05] = 8'hC3;
        spi_frame(inst, 16, {48'h0, 1'b1, 7'h05, 8'h00}, seen, sel_ok);
        n_cmp++;
        if (seen[15:0] !== 16'h00C3) begin
            n_bad++;
            $display("[TB] FAIL mode_miso%0d: got %h want 00c3", inst, seen[15:0]);
        end
        n_cmp++;
        if (rd_addr_q.size() < 1 || rd_addr_q[0] !== 7'h05 || err_cnt !== 0 || sel_ok !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL mode_addr%0d: got n=%0d err=%0d busy_ok=%b want addr 05, 0, 1",
                     inst, rd_addr_q.size(), err_cnt, sel_ok);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] seen;
        logic sel_ok;
        mem[7'h40] = 8'hFF;
        mem[7'h41] = 8'hFF;
        spi_begin(0);
        spi_shift(0, 20, {44'h0, 1'b1, 7'h40, 12'h000}, seen, sel_ok);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wr_en, rd_en, frame_err, busy, miso_oe, miso} !== 24'h0 || reg_addr !== 28'h0 || wr_data !== 32'h0) begin
            n_bad++;
            $display("[TB] FAIL midreset_outputs: got %h addr %h want 0",
                     {wr_en, rd_en, frame_err, busy, miso_oe, miso}, reg_addr);
        end
        clear_logs();
        spi_shift(0, 4, 64'hF, seen, sel_ok);
        ssel = '1;
        wait_clks(HP);
        rst_n = 1'b1;
        wait_clks(4 * HP);
        n_cmp++;
        if (wr_cnt + rd_cnt + err_cnt !== 0 || busy !== 4'h0) begin
            n_bad++;
            $display("[TB] FAIL midreset_quiet: got wr=%0d rd=%0d err=%0d busy=%h want 0", wr_cnt, rd_cnt, err_cnt, busy);
        end
        clear_logs();
        spi_frame(0, 16, {48'h0, 1'b1, 7'h05, 8'h00}, seen, sel_ok);
        n_cmp++;
        if (seen[15:0] !== 16'h00C3 || rd_cnt !== 2 || rd_addr_q[0] !== 7'h05) begin
            n_bad++;
            $display("[TB] FAIL midreset_next: got miso=%h rd=%0d want 00c3 2", seen[15:0], rd_cnt);
        end
    endtask

    task automatic test_strobe_rules();
        n_cmp++;
        if (clash_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL strobe_clash: got %0d want 0", clash_cnt);
        end
        n_cmp++;
        if (wide_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL strobe_width: got %0d want 0", wide_cnt);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_write_mode0();
        test_read_mode0();
        test_burst_write(0, {7'h7E, 7'h7F, 7'h00});
        test_burst_write(1, {7'h7E, 7'h7E, 7'h7E});
        test_read_burst();
        test_partial_frame();
        test_modes(2);
        test_modes(3);
        test_reset_mid_burst();
        test_strobe_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter ADDR_W, default 7, register address width.
REQ-002 Parameter DATA_W, default 8, register data width.
REQ-003 Parameter SPI_MODE, default 0, SPI mode 0..3: bit1 = CPOL, bit0 = CPHA.
REQ-004 Parameter AUTO_INC, default 1; 1 = burst address auto-increment, 0 = fixed address.
REQ-005 clk  input  1  system clock; all logic runs on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 DSP_SSEL  input  1  SPI chip select, active low, asynchronous to clk.
REQ-008 DSP_SCK  input  1  SPI clock, asynchronous to clk, at most clk/8.
REQ-009 DSP_MOSI  input  1  SPI serial data in.
REQ-010 DSP_MISO  output  1  SPI serial data out.
REQ-011 DSP_MISO_OE  output  1  MISO output enable, high while the frame is selected.
REQ-012 wr_en  output  1  one-clk write strobe.
REQ-013 rd_en  output  1  one-clk read request.
REQ-014 reg_addr  output  ADDR_W  address for wr_en/rd_en.
REQ-015 wr_data  output  DATA_W  write data, valid with wr_en.
REQ-016 rd_data  input  DATA_W  read data, sampled exactly 1 clk after rd_en.
REQ-017 busy  output  1  high while DSP_SSEL (synchronised) is low.
REQ-018 frame_err  output  1  one-clk pulse when a frame ends on a partial word.

Function
REQ-019 SSEL, SCK and MOSI shall pass through 2-flop synchronisers; SCK edges are detected on the synchronised signal.
REQ-020 Sample edge = rising if CPOL==CPHA, else falling; shift edge = the other edge.
REQ-021 Frame format, MSB first: 1 rw bit (1 = read), ADDR_W address bits, then N >= 0 data words of DATA_W bits while SSEL stays low.
REQ-022 FSM states are IDLE, CMD, DATA. IDLE->CMD on SSEL fall. CMD->DATA after ADDR_W+1 samples. DATA stays in DATA across words. Any state->IDLE on SSEL rise.
REQ-023 Write: on the clk after the DATA_W-th sample of each word, pulse wr_en with reg_addr and the word; then advance the address.
REQ-024 Read: on the clk after the last address sample, pulse rd_en. Capture rd_data 1 clk later into the shift register.
REQ-025 Read, each later word: pulse rd_en for the next address on the clk after that word's last sample (prefetch); capture it when the current word completes.
REQ-026 MISO shall present the shift register MSB before the first shift edge of each data word and advance one bit per shift edge.
REQ-027 For CPHA=1, the first data bit shall be driven on the leading edge of the first data-bit SCK cycle.
REQ-028 MISO shall be 0 during CMD, during write frames, and in IDLE.
REQ-029 Address advance: +1 modulo 2^ADDR_W when AUTO_INC=1; unchanged when AUTO_INC=0. 0x7F wraps to 0x00 at ADDR_W=7.
REQ-030 SSEL rise with a partial word (CMD incomplete, or 1..DATA_W-1 data bits): no wr_en for that word, frame_err pulses one clk, bit counter clears.
REQ-031 A frame ending on a word boundary gives no frame_err. A trailing read prefetch is allowed and harmless.
REQ-032 wr_en and rd_en shall never be high in the same clk. Each strobe is exactly one clk wide.
REQ-033 SSEL rise takes priority over a coincident SCK edge; that edge is ignored.

Reset
REQ-034 While rst_n is low: FSM in IDLE, counters 0, synchronisers reset to idle levels (SSEL=1, SCK=CPOL).
REQ-035 While rst_n is low: wr_en=0, rd_en=0, reg_addr=0, wr_data=0, DSP_MISO=0, DSP_MISO_OE=0, busy=0, frame_err=0.
REQ-036 Reset asserted mid-frame aborts the frame with no strobes. After release, the block waits for a fresh SSEL fall.

Structure
REQ-037 A shared package spi_reg_pkg holds the FSM state encoding, the SPI_MODE bit positions, and the bit-counter width function (clog2 of max(ADDR_W+1, DATA_W)).
REQ-038 One sub-module, spi_sync_edge, implements the synchroniser and SCK rise/fall detection. All remaining logic is in spi_reg_bridge.

Verification (ADDR_W=7, DATA_W=8 unless stated)
REQ-039 Mode 0 write, bits 0|0x12|0xA5 -> one wr_en, reg_addr=0x12, wr_data=0xA5, no rd_en, frame_err=0.
REQ-040 Mode 0 read 1|0x34, with rd_data=0x5A returned 1 clk after rd_en -> rd_en at reg_addr=0x34; MISO bits 0,1,0,1,1,0,1,0.
REQ-041 Burst write at 0x7E of words 0x01,0x02,0x03 -> three wr_en at addresses 0x7E, 0x7F, 0x00. With AUTO_INC=0 -> all three at 0x7E.
REQ-042 SSEL rise after 5 data bits of a write -> no wr_en, one frame_err pulse; the next full frame completes normally.
REQ-043 rst_n low mid-read-burst -> all outputs at reset values immediately; no strobes until the next full frame.
REQ-044 SPI_MODE=3 and SPI_MODE=1 read of 0xC3 at 0x05 -> MISO sampled on the correct edge returns 0xC3.
